// File: rtl/lm75_poll_scheduler.sv
// Periodic LM75 temperature read over a byte-level I2C master command/response port,
// with NACK/timeout retry. Optional Fahrenheit output is built when FAHRENHEIT_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_en and an expired poll timer
// START    | START condition
// ADDR_W   | WRITE {DEV_ADDR,0}
// PTR      | WRITE temperature pointer 8'h00
// RSTART   | repeated START
// ADDR_R   | WRITE {DEV_ADDR,1}
// RD_MSB   | READ_ACK, capture MSB
// RD_LSB   | READ_NACK, capture LSB
// STOP     | STOP closing a good transaction
// ERR_STOP | STOP after a NACKed write, then retry
// UPDATE   | publish temperature for one cycle
module lm75_poll_scheduler #(
  parameter int unsigned POLL_CYCLES    = 12_500_000,
  parameter logic [6:0]  DEV_ADDR       = 7'h48,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_en,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd,
  output logic [7:0] cmd_wdata,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_rdata,
  input  logic       rsp_nack,
  output logic [7:0] temp_celsius,
  output logic       temp_half,
  output logic [9:0] temp_fahrenheit,
  output logic       temp_valid,
  output logic       sensor_fault,
  output logic       busy
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WRITE   = 3'd1;
  localparam logic [2:0] CMD_RD_ACK  = 3'd2;
  localparam logic [2:0] CMD_RD_NACK = 3'd3;
  localparam logic [2:0] CMD_STOP    = 3'd4;

  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_PTR, S_RSTART, S_ADDR_R,
    S_RD_MSB, S_RD_LSB, S_STOP, S_ERR_STOP, S_UPDATE
  } state_t;

  function automatic logic [2:0] cmd_of(input state_t s);
    case (s)
      S_START, S_RSTART:        cmd_of = CMD_START;
      S_ADDR_W, S_PTR, S_ADDR_R: cmd_of = CMD_WRITE;
      S_RD_MSB:                 cmd_of = CMD_RD_ACK;
      S_RD_LSB:                 cmd_of = CMD_RD_NACK;
      default:                  cmd_of = CMD_STOP;
    endcase
  endfunction

  function automatic logic [7:0] wdata_of(input state_t s);
    case (s)
      S_ADDR_W: wdata_of = {DEV_ADDR, 1'b0};
      S_ADDR_R: wdata_of = {DEV_ADDR, 1'b1};
      default:  wdata_of = 8'h00;
    endcase
  endfunction

  function automatic logic is_write(input state_t s);
    is_write = (s == S_ADDR_W) || (s == S_PTR) || (s == S_ADDR_R);
  endfunction

`ifdef FAHRENHEIT_EN
  // 12-bit signed covers C*9 over the full LM75 range; '/' truncates toward zero
  function automatic logic [9:0] c_to_f(input logic [7:0] c);
    logic signed [11:0] c9;
    logic signed [11:0] q;
    c9 = $signed({{4{c[7]}}, c}) * 12'sd9;
    q  = c9 / 12'sd5;
    c_to_f = 10'(q + 12'sd32);
  endfunction
`endif

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [7:0]      msb_q, msb_d;
  logic            half_rx_q, half_rx_d;
  logic [7:0]      temp_c_q, temp_c_d;
  logic            temp_half_q, temp_half_d;
  logic            temp_valid_q, temp_valid_d;
  logic            fault_q, fault_d;
  logic            busy_q, busy_d;
`ifdef FAHRENHEIT_EN
  logic [9:0]      temp_f_q, temp_f_d;
`endif

  logic            enter;
  state_t          nxt;
  logic            retry_req;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_d        = cmd_q;
    wdata_d      = wdata_q;
    tmo_d        = (tmo_q != '0) ? tmo_q - TW'(1) : '0;
    poll_d       = (poll_q != '0) ? poll_q - PW'(1) : '0;
    retry_d      = retry_q;
    msb_d        = msb_q;
    half_rx_d    = half_rx_q;
    temp_c_d     = temp_c_q;
    temp_half_d  = temp_half_q;
    temp_valid_d = 1'b0;
    fault_d      = fault_q;
    busy_d       = busy_q;
`ifdef FAHRENHEIT_EN
    temp_f_d     = temp_f_q;
`endif
    enter        = 1'b0;
    nxt          = state_q;
    retry_req    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_en && (poll_q == '0)) begin
          enter   = 1'b1;
          nxt     = S_START;
          retry_d = '0;
          poll_d  = POLL_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default: begin
        if (!phase_q) begin
          if (cmd_valid_q && cmd_ready) begin
            phase_d     = 1'b1;
            cmd_valid_d = 1'b0;
            cmd_d       = CMD_START;
            wdata_d     = 8'h00;
            tmo_d       = TMO_LOAD;
          end else if (tmo_q == '0) begin
            retry_req = 1'b1;
          end
        end else if (rsp_valid) begin
          if (is_write(state_q) && rsp_nack) begin
            enter = 1'b1;
            nxt   = S_ERR_STOP;
          end else begin
            enter = 1'b1;
            case (state_q)
              S_START:  nxt = S_ADDR_W;
              S_ADDR_W: nxt = S_PTR;
              S_PTR:    nxt = S_RSTART;
              S_RSTART: nxt = S_ADDR_R;
              S_ADDR_R: nxt = S_RD_MSB;
              S_RD_MSB: begin
                nxt   = S_RD_LSB;
                msb_d = rsp_rdata;
              end
              S_RD_LSB: begin
                nxt       = S_STOP;
                half_rx_d = rsp_rdata[7];
              end
              S_STOP: begin
                enter        = 1'b0;
                state_d      = S_UPDATE;
                busy_d       = 1'b0;
                temp_c_d     = msb_q;
                temp_half_d  = half_rx_q;
                temp_valid_d = 1'b1;
                fault_d      = 1'b0;
`ifdef FAHRENHEIT_EN
                temp_f_d     = c_to_f(msb_q);
`endif
              end
              default: begin
                enter     = 1'b0;
                retry_req = 1'b1;
              end
            endcase
          end
        end else if (tmo_q == '0) begin
          retry_req = 1'b1;
        end
      end
    endcase

    if (retry_req) begin
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + RW'(1);
        enter   = 1'b1;
        nxt     = S_START;
      end else begin
        state_d     = S_IDLE;
        phase_d     = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_d       = CMD_START;
        wdata_d     = 8'h00;
        busy_d      = 1'b0;
        fault_d     = 1'b1;
      end
    end

    // every command state opens with its command already registered for the next cycle
    if (enter) begin
      state_d     = nxt;
      phase_d     = 1'b0;
      cmd_valid_d = 1'b1;
      cmd_d       = cmd_of(nxt);
      wdata_d     = wdata_of(nxt);
      tmo_d       = TMO_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= 3'd0;
      wdata_q      <= 8'h00;
      tmo_q        <= '0;
      poll_q       <= '0;
      retry_q      <= '0;
      msb_q        <= 8'h00;
      half_rx_q    <= 1'b0;
      temp_c_q     <= 8'h00;
      temp_half_q  <= 1'b0;
      temp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FAHRENHEIT_EN
      temp_f_q     <= 10'd0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      wdata_q      <= wdata_d;
      tmo_q        <= tmo_d;
      poll_q       <= poll_d;
      retry_q      <= retry_d;
      msb_q        <= msb_d;
      half_rx_q    <= half_rx_d;
      temp_c_q     <= temp_c_d;
      temp_half_q  <= temp_half_d;
      temp_valid_q <= temp_valid_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
`ifdef FAHRENHEIT_EN
      temp_f_q     <= temp_f_d;
`endif
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd          = cmd_q;
  assign cmd_wdata    = wdata_q;
  assign temp_celsius = temp_c_q;
  assign temp_half    = temp_half_q;
  assign temp_valid   = temp_valid_q;
  assign sensor_fault = fault_q;
  assign busy         = busy_q;
`ifdef FAHRENHEIT_EN
  assign temp_fahrenheit = temp_f_q;
`else
  assign temp_fahrenheit = 10'd0;
`endif

endmodule
